// File: rtl/shift_sweep_pkg.sv
// Shared types and helpers for the shift sweep sequencer.
// Holds the sweep FSM state encoding and the data-width helper.
package shift_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RIGHT,
    LEFT,
    DONE
  } sweep_state_t;

  function automatic int data_width(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/shift_sweep_sequencer_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the final dwell cycle.
// With DWELL=1 the counter stays at zero, so last is permanently high.
module dwell_counter #(
  parameter int DWELL = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/shift_sweep_sequencer.sv
// Sweep sequencer feeding a barrel shifter: right rotates 1..2^N-1, then left rotates 1..2^N-1.
// Optional result checksum is built when SHIFT_SWEEP_CAPTURE_EN is defined.
module shift_sweep_sequencer
  import shift_sweep_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int DWELL = 200,
  localparam int W     = data_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] operand_i,
  output logic [W-1:0] num_o,
  output logic [N-1:0] shift_o,
  output logic         select_o,
  output logic         step_valid,
  output logic         busy,
  output logic         done
`ifdef SHIFT_SWEEP_CAPTURE_EN
  ,
  input  logic [W-1:0] result_i,
  output logic [W-1:0] checksum_o
`endif
);

  localparam logic [N-1:0] SHIFT_MAX = '1;
  localparam logic [N-1:0] SHIFT_ONE = N'(1);

  sweep_state_t   state, state_d;
  logic [W-1:0]   num_d;
  logic [N-1:0]   shift_d;
  logic           select_d;
  logic           last;

  assign busy       = (state == RIGHT) || (state == LEFT);
  assign step_valid = busy & last;
  assign done       = (state == DONE);

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clr  (step_valid | ~busy),
    .en   (busy),
    .last (last)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    num_d    = num_o;
    shift_d  = shift_o;
    select_d = select_o;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RIGHT;
          num_d    = operand_i;
          shift_d  = SHIFT_ONE;
          select_d = 1'b1;
        end
      end
      RIGHT, LEFT: begin
        // Abort takes priority over a step advance on the same edge.
        if (abort) begin
          state_d  = IDLE;
          shift_d  = '0;
          select_d = 1'b0;
        end else if (step_valid) begin
          if (shift_o != SHIFT_MAX) begin
            shift_d = shift_o + SHIFT_ONE;
          end else if (state == RIGHT) begin
            state_d  = LEFT;
            shift_d  = SHIFT_ONE;
            select_d = 1'b0;
          end else begin
            state_d  = DONE;
            shift_d  = '0;
            select_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      num_o    <= '0;
      shift_o  <= '0;
      select_o <= 1'b0;
    end else begin
      state    <= state_d;
      num_o    <= num_d;
      shift_o  <= shift_d;
      select_o <= select_d;
    end
  end

`ifdef SHIFT_SWEEP_CAPTURE_EN
  logic accept;
  assign accept = (state == IDLE) && start && !abort;

  // XOR of every sampled shifter result; left untouched by aborted edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_o <= '0;
    end else if (accept) begin
      checksum_o <= '0;
    end else if (step_valid && !abort) begin
      checksum_o <= checksum_o ^ result_i;
    end
  end
`endif

endmodule
